mii_rx_framer: RTL and testbench
================================

MII_RX_FRAMER -- requirements
Module: mii_rx_framer

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64: minimum good frame length in bytes, FCS included.
REQ-002 SHALL have parameter MAX_LEN, default 1518: maximum good frame length in bytes, FCS included.
REQ-003 SHALL have port RX_CLK, input, 1 bit: PHY MII receive clock (25 MHz at 100 Mb/s); the only clock.
REQ-004 SHALL have port RESETN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port RXD, input, 4 bits: MII receive nibble, sampled on the RX_CLK rising edge.
REQ-006 SHALL have port RXDV, input, 1 bit: MII receive data valid.
REQ-007 SHALL have port RXER, input, 1 bit: MII receive error.
REQ-008 SHALL have port DATA, output, 8 bits: assembled frame byte, destination MAC first, FCS included.
REQ-009 SHALL have port VALID, output, 1 bit: DATA qualifier, one-cycle pulse per byte.
REQ-010 SHALL have port SOF, output, 1 bit: asserted with VALID on the first byte after the SFD.
REQ-011 SHALL have port DONE, output, 1 bit: one-cycle end-of-frame pulse.
REQ-012 SHALL have port CRC_OK, output, 1 bit: frame status; valid while DONE=1.
REQ-013 SHALL have port ERR, output, 1 bit: frame status; valid while DONE=1.
REQ-014 SHALL have port LEN, output, 11 bits: frame length in bytes; valid while DONE=1.
REQ-015 SHALL have port GOOD_CNT, output, 16 bits: count of good frames.
REQ-016 SHALL have port BAD_CNT, output, 16 bits: count of bad frames.

Function
REQ-017 SHALL implement FSM states IDLE, PREAMBLE, BODY, DROP.
REQ-018 SHALL transition IDLE->PREAMBLE on RXDV=1 with RXD=0x5; IDLE->DROP on RXDV=1 with any other RXD.
REQ-019 SHALL, in PREAMBLE: stay on RXD=0x5; go to BODY on RXD=0xD (SFD); go to DROP on any other nibble or RXER=1; go to IDLE on RXDV=0. No DONE is produced in any of these cases.
REQ-020 SHALL, in BODY, take the first nibble of each pair as DATA[3:0] and the second as DATA[7:4], and pulse VALID the cycle after the second nibble is sampled.
REQ-021 SHALL assert SOF only on the first VALID of a frame.
REQ-022 SHALL run CRC-32 (polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF) over every BODY byte, FCS included; the CRC is good when the final residue equals 0xC704DD7B.
REQ-023 SHALL increment the byte counter once per completed byte, saturating at 2047.
REQ-024 SHALL, on RXDV falling in BODY, go to IDLE and pulse DONE the following cycle, with LEN = byte count and CRC_OK = (residue good).
REQ-025 SHALL assert ERR with DONE on any of: RXER=1 seen in BODY; odd nibble count (trailing nibble discarded, not counted); LEN<MIN_LEN; LEN>MAX_LEN; CRC bad.
REQ-026 SHALL, when DONE=1 and ERR=0, increment GOOD_CNT; when DONE=1 and ERR=1, increment BAD_CNT; both counters saturate at 0xFFFF.
REQ-027 SHALL stay in DROP with no VALID output until RXDV=0, then return to IDLE with no DONE and no counter change.
REQ-028 SHALL NOT emit VALID in the DONE cycle.
REQ-029 SHALL accept RXDV rising in the DONE cycle as a new frame start; back-to-back frames with zero idle cycles SHALL be handled.
REQ-030 SHALL hold DATA, CRC_OK, ERR and LEN stable until their next update.

Reset
REQ-031 SHALL, while RESETN=0, force state IDLE and drive VALID, SOF, DONE, CRC_OK, ERR = 0; DATA, LEN = 0; GOOD_CNT, BAD_CNT = 0; CRC register = 0xFFFFFFFF.
REQ-032 SHALL, on reset asserted mid-frame, abandon the frame with no DONE; after reset release, RXDV held high SHALL be treated as a fresh IDLE entry (non-0x5 nibble -> DROP).

Verification
REQ-033 SHALL cover: 15 nibbles of 0x5, SFD 0xD, 60-byte payload plus correct FCS -> 64 VALID pulses, SOF on the first, DONE with LEN=64, CRC_OK=1, ERR=0, GOOD_CNT=1.
REQ-034 SHALL cover: the same frame with one payload bit flipped -> DONE with CRC_OK=0, ERR=1, BAD_CNT=1, GOOD_CNT unchanged.
REQ-035 SHALL cover: RXER pulsed for 1 cycle mid-body of a CRC-good frame -> DONE with ERR=1, CRC_OK=1.
REQ-036 SHALL cover: a 40-byte frame with good CRC -> LEN=40, ERR=1; a 129-nibble body -> LEN=64, ERR=1.
REQ-037 SHALL cover: preamble broken by RXD=0x3 before the SFD -> no VALID, no DONE, counters unchanged; the next valid frame is received normally.
REQ-038 SHALL cover: RESETN pulled low after byte 20 of a frame -> all outputs 0 immediately, no DONE; the next frame is received with GOOD_CNT=1.

Source files
------------

// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, assembles nibbles into bytes,
// checks CRC-32 and frame length, and reports per-frame status and counts.
module mii_rx_framer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        RX_CLK,
  input  logic        RESETN,
  input  logic [3:0]  RXD,
  input  logic        RXDV,
  input  logic        RXER,
  output logic [7:0]  DATA,
  output logic        VALID,
  output logic        SOF,
  output logic        DONE,
  output logic        CRC_OK,
  output logic        ERR,
  output logic [10:0] LEN,
  output logic [15:0] GOOD_CNT,
  output logic [15:0] BAD_CNT
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, BODY, DROP} state_t;

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  // The shift register runs LSB-first, so the good-frame residue 0xC704DD7B
  // appears here in bit-reversed form.
  localparam logic [31:0] RESIDUE_REFL = 32'hDEBB20E3;

  state_t      state, state_nxt;
  logic [3:0]  nib_lo_p0;
  logic        phase_p0;
  logic        first_p0;
  logic        err_p0;
  logic [31:0] crc_p0;
  logic [10:0] cnt_p0;

  logic        body_start, nib_take, byte_done, frame_end, crc_good, frame_err;
  logic [7:0]  byte_now;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // State register
  always_ff @(posedge RX_CLK or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (RXDV) state_nxt = (RXD == 4'h5) ? PREAMBLE : DROP;
      PREAMBLE: begin
        if (!RXDV)              state_nxt = IDLE;
        else if (RXER)          state_nxt = DROP;
        else if (RXD == 4'hD)   state_nxt = BODY;
        else if (RXD != 4'h5)   state_nxt = DROP;
      end
      BODY:     if (!RXDV) state_nxt = IDLE;
      DROP:     if (!RXDV) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Control strobes and end-of-frame status derived from state and inputs
  always_comb begin
    body_start = (state == PREAMBLE) && RXDV && !RXER && (RXD == 4'hD);
    nib_take   = (state == BODY) && RXDV;
    byte_done  = nib_take && phase_p0;
    frame_end  = (state == BODY) && !RXDV;
    byte_now   = {RXD, nib_lo_p0};
    crc_good   = (crc_p0 == RESIDUE_REFL);
    frame_err  = err_p0 || phase_p0 || (cnt_p0 < MIN_L) || (cnt_p0 > MAX_L) || !crc_good;
  end

  // Byte assembly, CRC, length counting and frame status registers
  always_ff @(posedge RX_CLK or negedge RESETN) begin
    if (!RESETN) begin
      nib_lo_p0 <= '0;
      phase_p0  <= 1'b0;
      first_p0  <= 1'b0;
      err_p0    <= 1'b0;
      crc_p0    <= 32'hFFFFFFFF;
      cnt_p0    <= '0;
      DATA      <= '0;
      VALID     <= 1'b0;
      SOF       <= 1'b0;
      DONE      <= 1'b0;
      CRC_OK    <= 1'b0;
      ERR       <= 1'b0;
      LEN       <= '0;
      GOOD_CNT  <= '0;
      BAD_CNT   <= '0;
    end else begin
      VALID <= 1'b0;
      SOF   <= 1'b0;
      DONE  <= 1'b0;
      if (body_start) begin
        crc_p0   <= 32'hFFFFFFFF;
        cnt_p0   <= '0;
        phase_p0 <= 1'b0;
        err_p0   <= 1'b0;
        first_p0 <= 1'b1;
      end
      if (nib_take) begin
        if (RXER) err_p0 <= 1'b1;
        if (!phase_p0) begin
          nib_lo_p0 <= RXD;
          phase_p0  <= 1'b1;
        end else begin
          phase_p0 <= 1'b0;
          DATA     <= byte_now;
          VALID    <= 1'b1;
          SOF      <= first_p0;
          first_p0 <= 1'b0;
          crc_p0   <= crc_next(crc_p0, byte_now);
          cnt_p0   <= sat_inc11(cnt_p0);
        end
      end
      if (frame_end) begin
        DONE   <= 1'b1;
        LEN    <= cnt_p0;
        CRC_OK <= crc_good;
        ERR    <= frame_err;
        if (frame_err) BAD_CNT  <= sat_inc16(BAD_CNT);
        else           GOOD_CNT <= sat_inc16(GOOD_CNT);
      end
    end
  end

endmodule

// File: tb/tb_mii_rx_framer.sv
// Testbench for mii_rx_framer: table of whole-frame vectors plus hand-written
// sequences for broken preamble and mid-frame reset.
module tb_mii_rx_framer;

  logic        RX_CLK;
  logic        RESETN;
  logic [3:0]  RXD;
  logic        RXDV;
  logic        RXER;
  logic [7:0]  DATA;
  logic        VALID, SOF, DONE, CRC_OK, ERR;
  logic [10:0] LEN;
  logic [15:0] GOOD_CNT, BAD_CNT;

  mii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .RX_CLK(RX_CLK), .RESETN(RESETN), .RXD(RXD), .RXDV(RXDV), .RXER(RXER),
    .DATA(DATA), .VALID(VALID), .SOF(SOF), .DONE(DONE), .CRC_OK(CRC_OK),
    .ERR(ERR), .LEN(LEN), .GOOD_CNT(GOOD_CNT), .BAD_CNT(BAD_CNT)
  );

  initial RX_CLK = 1'b0;
  always #20 RX_CLK = ~RX_CLK;

  typedef struct {
    int          payload;
    int          flip;
    logic        odd;
    int          rxer_nib;
    int          idle;
    logic [31:0] elen;
    logic [31:0] ecrc;
    logic [31:0] eerr;
    logic [31:0] egood;
    logic [31:0] ebad;
    logic [31:0] envalid;
  } vec_t;

  typedef struct {
    logic [31:0] len;
    logic [31:0] crc_ok;
    logic [31:0] err;
    logic [31:0] good;
    logic [31:0] bad;
    logic [31:0] nvalid;
  } res_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  fb [0:2047];
  int          fn;
  logic [7:0]  exp_mem [0:8191];
  int          wr = 0;
  int          rd = 0;
  int          nv = 0;
  bit          cap_pending = 0;
  res_t        cur;
  res_t        res [$];
  vec_t        tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++)
      r = (r[0] ^ b[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Observe DUT outputs at the falling edge; byte stream checked against exp_mem
  task automatic sample();
    if (VALID) begin
      if (rd < wr) chk("data", 32'(DATA), 32'(exp_mem[rd]));
      else         chk("spurious_valid", 32'(VALID), 32'd0);
      rd++;
    end
    if (VALID || SOF) begin
      chk("sof", 32'(SOF), 32'(VALID && (nv == 0)));
      if (VALID) nv++;
    end
    if (cap_pending) begin
      cur.good = 32'(GOOD_CNT);
      cur.bad  = 32'(BAD_CNT);
      res.push_back(cur);
      cap_pending = 0;
    end
    if (DONE) begin
      chk("valid_with_done", 32'(VALID), 32'd0);
      cur.len    = 32'(LEN);
      cur.crc_ok = 32'(CRC_OK);
      cur.err    = 32'(ERR);
      cur.nvalid = 32'(nv);
      nv = 0;
      cap_pending = 1;
    end
  endtask

  task automatic tick(input logic dv, input logic [3:0] d, input logic er);
    @(negedge RX_CLK);
    sample();
    RXDV = dv;
    RXD  = d;
    RXER = er;
  endtask

  task automatic build_frame(input int payload, input int flip);
    logic [31:0] c, fcs;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < payload; i++) begin
      fb[i] = 8'((i * 37 + 11) & 255);
      c = crc_upd(c, fb[i]);
    end
    fcs = ~c;
    fb[payload]     = fcs[7:0];
    fb[payload + 1] = fcs[15:8];
    fb[payload + 2] = fcs[23:16];
    fb[payload + 3] = fcs[31:24];
    fn = payload + 4;
    if (flip >= 0) fb[flip] = fb[flip] ^ 8'h01;
  endtask

  task automatic send_preamble();
    repeat (15) tick(1'b1, 4'h5, 1'b0);
    tick(1'b1, 4'hD, 1'b0);
  endtask

  task automatic send_bytes(input int n, input int rxer_nib);
    for (int i = 0; i < n; i++) begin
      exp_mem[wr] = fb[i];
      wr++;
      tick(1'b1, fb[i][3:0], (2 * i == rxer_nib));
      tick(1'b1, fb[i][7:4], (2 * i + 1 == rxer_nib));
    end
  endtask

  task automatic send_frame(input int payload, input int flip, input logic odd,
                            input int rxer_nib, input int idle);
    build_frame(payload, flip);
    send_preamble();
    send_bytes(fn, rxer_nib);
    if (odd) tick(1'b1, 4'hA, 1'b0);
    tick(1'b0, 4'h0, 1'b0);
    repeat (idle) tick(1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    // payload, flip, odd, rxer_nib, idle | len, crc_ok, err, good, bad, nvalid
    tbl[0] = '{60,   -1, 1'b0, -1, 2, 64,   1, 0, 1, 0, 64};
    tbl[1] = '{60,   10, 1'b0, -1, 0, 64,   0, 1, 1, 1, 64};
    tbl[2] = '{60,   -1, 1'b0, 50, 0, 64,   1, 1, 1, 2, 64};
    tbl[3] = '{36,   -1, 1'b0, -1, 1, 40,   1, 1, 1, 3, 40};
    tbl[4] = '{60,   -1, 1'b1, -1, 0, 64,   1, 1, 1, 4, 64};
    tbl[5] = '{1514, -1, 1'b0, -1, 0, 1518, 1, 0, 2, 4, 1518};
    tbl[6] = '{1515, -1, 1'b0, -1, 0, 1519, 1, 1, 2, 5, 1519};
    tbl[7] = '{60,   -1, 1'b0, -1, 4, 64,   1, 0, 3, 5, 64};

    RESETN = 1'b0;
    RXDV = 1'b0;
    RXD = 4'h0;
    RXER = 1'b0;
    repeat (3) tick(1'b0, 4'h0, 1'b0);
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_sof", 32'(SOF), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_crc_ok", 32'(CRC_OK), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_data", 32'(DATA), 32'd0);
    chk("rst_len", 32'(LEN), 32'd0);
    chk("rst_good", 32'(GOOD_CNT), 32'd0);
    chk("rst_bad", 32'(BAD_CNT), 32'd0);
    RESETN = 1'b1;
    repeat (2) tick(1'b0, 4'h0, 1'b0);

    for (int i = 0; i < 8; i++)
      send_frame(tbl[i].payload, tbl[i].flip, tbl[i].odd, tbl[i].rxer_nib, tbl[i].idle);
    repeat (6) tick(1'b0, 4'h0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      if (res.size() > i) begin
        chk($sformatf("v%0d_len", i),    res[i].len,    tbl[i].elen);
        chk($sformatf("v%0d_crc_ok", i), res[i].crc_ok, tbl[i].ecrc);
        chk($sformatf("v%0d_err", i),    res[i].err,    tbl[i].eerr);
        chk($sformatf("v%0d_good", i),   res[i].good,   tbl[i].egood);
        chk($sformatf("v%0d_bad", i),    res[i].bad,    tbl[i].ebad);
        chk($sformatf("v%0d_nvalid", i), res[i].nvalid, tbl[i].envalid);
      end else begin
        chk($sformatf("v%0d_done_count", i), 32'(res.size()), 32'(i + 1));
      end
    end

    // Preamble broken by 0x3: whole burst dropped, nothing reported
    repeat (4) tick(1'b1, 4'h5, 1'b0);
    tick(1'b1, 4'h3, 1'b0);
    repeat (3) tick(1'b1, 4'h5, 1'b0);
    tick(1'b1, 4'hD, 1'b0);
    for (int k = 0; k < 20; k++) tick(1'b1, 4'(k), 1'b0);
    repeat (3) tick(1'b0, 4'h0, 1'b0);
    chk("broken_no_done", 32'(res.size()), 32'd8);
    chk("broken_good", 32'(GOOD_CNT), 32'd3);
    chk("broken_bad", 32'(BAD_CNT), 32'd5);
    send_frame(60, -1, 1'b0, -1, 3);
    chk("after_broken_count", 32'(res.size()), 32'd9);
    if (res.size() > 8) begin
      chk("after_broken_len", res[8].len, 32'd64);
      chk("after_broken_err", res[8].err, 32'd0);
      chk("after_broken_good", res[8].good, 32'd4);
    end

    // Reset asserted after byte 20 of a frame
    build_frame(60, -1);
    send_preamble();
    send_bytes(20, -1);
    tick(1'b1, 4'h7, 1'b0);
    @(negedge RX_CLK);
    RESETN = 1'b0;
    #1;
    chk("midrst_valid", 32'(VALID), 32'd0);
    chk("midrst_sof", 32'(SOF), 32'd0);
    chk("midrst_done", 32'(DONE), 32'd0);
    chk("midrst_crc_ok", 32'(CRC_OK), 32'd0);
    chk("midrst_err", 32'(ERR), 32'd0);
    chk("midrst_data", 32'(DATA), 32'd0);
    chk("midrst_len", 32'(LEN), 32'd0);
    chk("midrst_good", 32'(GOOD_CNT), 32'd0);
    chk("midrst_bad", 32'(BAD_CNT), 32'd0);
    rd = wr;
    nv = 0;
    cap_pending = 0;
    repeat (2) tick(1'b1, 4'h7, 1'b0);
    RESETN = 1'b1;
    repeat (4) tick(1'b1, 4'h7, 1'b0);
    repeat (3) tick(1'b0, 4'h0, 1'b0);
    chk("midrst_no_done", 32'(res.size()), 32'd9);
    chk("midrst_good_after", 32'(GOOD_CNT), 32'd0);
    send_frame(60, -1, 1'b0, -1, 3);
    chk("post_rst_count", 32'(res.size()), 32'd10);
    if (res.size() > 9) begin
      chk("post_rst_len", res[9].len, 32'd64);
      chk("post_rst_crc_ok", res[9].crc_ok, 32'd1);
      chk("post_rst_err", res[9].err, 32'd0);
      chk("post_rst_good", res[9].good, 32'd1);
      chk("post_rst_bad", res[9].bad, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
